sd_cmd_phy: RTL

- Serialises one SD command frame onto the CMD line and, optionally, captures and checks the 48-bit response.
- Clocked by the selectable SD clock (`oclk_sd`) produced by the clock divider. Runs identically at slow (identification) and fast (transfer) rates.
- Sits between the SD card controller FSM (command issuer) and the CMD pad tristate buffer.

---
 rtl/sd_cmd_phy.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: serialises one 48-bit command frame with serial CRC7 and
// optionally captures and checks the 48-bit response, then idles P_NCC cycles.
module sd_cmd_phy #(
  parameter int P_NCR = 64,
  parameter int P_NCC = 8
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istart,
  input  logic [5:0]  icmd_index,
  input  logic [31:0] iarg,
  input  logic        iresp_en,
  input  logic        icrc_chk,
  input  logic        icmd_i,
  output logic        ocmd_o,
  output logic        ocmd_oe,
  output logic        obusy,
  output logic        odone,
  output logic [5:0]  oresp_index,
  output logic [31:0] oresp,
  output logic        ocrc_err,
  output logic        otimeout
);

  localparam int TMAX = (P_NCR > P_NCC) ? P_NCR : P_NCC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] NCR_LAST = TW'(P_NCR - 1);
  localparam logic [TW-1:0] NCC_LAST = TW'(P_NCC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [38:0]   tx_q, tx_d;
  logic [45:0]   rx_q, rx_d;
  logic [5:0]    bit_q, bit_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [6:0]    crc_q, crc_d;
  logic          resp_en_q, resp_en_d;
  logic          crc_chk_q, crc_chk_d;
  logic          cmd_o_q, cmd_o_d;
  logic          cmd_oe_q, cmd_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [5:0]    resp_index_q, resp_index_d;
  logic [31:0]   resp_q, resp_d;
  logic          crc_err_q, crc_err_d;
  logic          timeout_q, timeout_d;

  logic [5:0]    bit_nxt;
  logic [46:0]   rx_full;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  // bit_q holds the frame index of the bit currently on (or just taken from) the line.
  assign bit_nxt = bit_q - 6'd1;
  assign rx_full = {rx_q, icmd_i};

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_d        = bit_q;
    tmr_d        = tmr_q;
    crc_d        = crc_q;
    resp_en_d    = resp_en_q;
    crc_chk_d    = crc_chk_q;
    cmd_o_d      = cmd_o_q;
    cmd_oe_d     = cmd_oe_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resp_index_d = resp_index_q;
    resp_d       = resp_q;
    crc_err_d    = crc_err_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        cmd_oe_d = 1'b0;
        cmd_o_d  = 1'b1;
        if (istart) begin
          tx_d         = {1'b1, icmd_index, iarg};
          resp_en_d    = iresp_en;
          crc_chk_d    = icrc_chk;
          bit_d        = 6'd47;
          crc_d        = 7'd0;
          cmd_o_d      = 1'b0;
          cmd_oe_d     = 1'b1;
          busy_d       = 1'b1;
          resp_index_d = 6'd0;
          resp_d       = 32'd0;
          crc_err_d    = 1'b0;
          timeout_d    = 1'b0;
          state_d      = S_SEND;
        end
      end

      S_SEND: begin
        bit_d = bit_nxt;
        if (bit_q == 6'd0) begin
          cmd_oe_d = 1'b0;
          cmd_o_d  = 1'b1;
          tmr_d    = '0;
          crc_d    = 7'd0;
          state_d  = resp_en_q ? S_WAIT : S_GAP;
        end else if (bit_nxt >= 6'd8) begin
          cmd_o_d = tx_q[38];
          tx_d    = {tx_q[37:0], 1'b0};
          crc_d   = crc7_step(crc_q, tx_q[38]);
        end else if (bit_nxt != 6'd0) begin
          cmd_o_d = crc_q[6];
          crc_d   = {crc_q[5:0], 1'b0};
        end else begin
          cmd_o_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (!icmd_i) begin
          // This sample is the response start bit; a zero leaves the CRC at zero.
          rx_d    = '0;
          bit_d   = 6'd47;
          crc_d   = 7'd0;
          state_d = S_RECV;
        end else if (tmr_q == NCR_LAST) begin
          timeout_d = 1'b1;
          tmr_d     = '0;
          state_d   = S_GAP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_RECV: begin
        rx_d  = rx_full[45:0];
        bit_d = bit_nxt;
        if (bit_nxt >= 6'd8) begin
          crc_d = crc7_step(crc_q, icmd_i);
        end
        if (bit_nxt == 6'd0) begin
          resp_index_d = rx_full[45:40];
          resp_d       = rx_full[39:8];
          crc_err_d    = rx_full[46] | ~rx_full[0] |
                         (crc_chk_q & (rx_full[7:1] != crc_q));
          tmr_d        = '0;
          state_d      = S_GAP;
        end
      end

      S_GAP: begin
        if (tmr_q == NCC_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      default: begin
        cmd_oe_d = 1'b0;
        cmd_o_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q      <= S_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_q        <= 6'd0;
      tmr_q        <= '0;
      crc_q        <= 7'd0;
      resp_en_q    <= 1'b0;
      crc_chk_q    <= 1'b0;
      cmd_o_q      <= 1'b1;
      cmd_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_index_q <= 6'd0;
      resp_q       <= 32'd0;
      crc_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_q        <= bit_d;
      tmr_q        <= tmr_d;
      crc_q        <= crc_d;
      resp_en_q    <= resp_en_d;
      crc_chk_q    <= crc_chk_d;
      cmd_o_q      <= cmd_o_d;
      cmd_oe_q     <= cmd_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_index_q <= resp_index_d;
      resp_q       <= resp_d;
      crc_err_q    <= crc_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ocmd_o      = cmd_o_q;
  assign ocmd_oe     = cmd_oe_q;
  assign obusy       = busy_q;
  assign odone       = done_q;
  assign oresp_index = resp_index_q;
  assign oresp       = resp_q;
  assign ocrc_err    = crc_err_q;
  assign otimeout    = timeout_q;

endmodule
